mc_main_ctrl: RTL
=================

Name: mc_main_ctrl

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Decodes the 6-bit opcode (plus Func for jr) held in the instruction register.
- Sequences fetch/decode/execute/memory/writeback and drives all datapath enables.
- Produces the 3-bit Aluop that the ALU control stage consumes. Sits directly upstream of it.
- Stalls on a memory-ready handshake.

Parameters:
- OP_R, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate
- OP_ANDI, 6'b001100, and immediate
- F_JR, 6'b001000, Func code of jr

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  6  opcode from IR (stable from end of FETCH until next FETCH)
- Func  in  6  function field from IR
- Mem_Rdy  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
- Aluop  out  3  to ALU control: 000 R-type(Func), 001 lw, 010 add, 011 andi, 110 beq
- Illegal  out  1  unrecognised opcode/Func seen in DECODE
- State  out  4  current state (debug)

Behaviour:
- 4-bit state register, sole sequential element. rst forces RST immediately, mid-instruction included.
- Outputs are combinational from state (plus Op, Func, Mem_Rdy where noted). Every output not listed for a state is 0.
- RST (0): all outputs 0. Goes to FETCH on the first clk edge after rst deasserts.
- FETCH (1):
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Aluop=010, PCSource=00.
  - IRWrite=PCWrite=Mem_Rdy.
  - Stays in FETCH while Mem_Rdy=0. Goes to DECODE when Mem_Rdy=1.
- DECODE (2): ALUSrcA=0, ALUSrcB=11, Aluop=010. Next state by Op:
  - LW/SW -> MEMADR; R -> EXEC (JR if Func=F_JR); BEQ -> BRANCH; J -> JUMP; ADDI/ANDI -> IMMEX.
  - Any other Op -> FETCH, with Illegal=1 this cycle.
  - R-type with Func not in {100000,100010,100100,000000,101010,001000} also asserts Illegal and goes to FETCH.
- MEMADR (3): ALUSrcA=1, ALUSrcB=10. Aluop=001 if Op=LW, else 010. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD (4): MemRead=1, IorD=1. Holds until Mem_Rdy, then goes to MEMWB.
- MEMWB (5): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR (6): MemWrite=1, IorD=1. Holds until Mem_Rdy, then goes to FETCH.
- EXEC (7): ALUSrcA=1, ALUSrcB=00, Aluop=000. Goes to ALUWB.
- ALUWB (8): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, Aluop=110, PCWriteCond=1, PCSource=01. Goes to FETCH.
- IMMEX (10): ALUSrcA=1, ALUSrcB=10. Aluop=010 for ADDI, 011 for ANDI. Goes to IMMWB.
- IMMWB (11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP (12): PCWrite=1, PCSource=10. Goes to FETCH.
- JR (13): PCWrite=1, PCSource=11. Goes to FETCH.
- Unused encodings 14/15 go to FETCH with all outputs 0.
- Latency with Mem_Rdy tied 1, counted as cycles from FETCH entry to next FETCH:
  - lw 5; sw, R-type, addi, andi 4; beq, j, jr 3.
- Each Mem_Rdy=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle. Request signals stay asserted throughout the stall.
- Mem_Rdy is ignored in all other states.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1.

Test Plan:
- rst=1 mid-MEMRD -> State=0 asynchronously, all outputs 0. One clk after release -> State=1, MemRead=1, Aluop=010.
- Mem_Rdy=1, Op=100011 -> states 1,2,3,4,5,1. Aluop=001 in MEMADR. MemtoReg=RegWrite=1 in MEMWB.
- Op=000000, Func=100000 -> states 1,2,7,8,1. Aluop=000 in EXEC. RegDst=1 in ALUWB.
- Op=001100 -> Aluop=011 in IMMEX. Op=000100 -> Aluop=110, PCWriteCond=1, PCSource=01 in BRANCH.
- Op=101011 with Mem_Rdy low for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, then FETCH.
- Op=111111 -> Illegal=1 in DECODE, next state FETCH. Op=000000, Func=001000 -> JR: PCWrite=1, PCSource=11.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables plus the 3-bit Aluop consumed by ALU control.
module mc_main_ctrl #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter logic [5:0] OP_ADDI = 6'b001000,
  parameter logic [5:0] OP_ANDI = 6'b001100,
  parameter logic [5:0] F_JR    = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Mem_Rdy,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] Aluop,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  assign State = state;

  always_comb begin
    state_nxt   = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    Aluop       = 3'b000;
    Illegal     = 1'b0;

    case (state)
      S_RST: state_nxt = S_FETCH;

      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        Aluop     = 3'b010;
        IRWrite   = Mem_Rdy;
        PCWrite   = Mem_Rdy;
        state_nxt = Mem_Rdy ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        Aluop   = 3'b010;
        if (Op == OP_LW || Op == OP_SW) begin
          state_nxt = S_MEMADR;
        end else if (Op == OP_R) begin
          // Unsupported R-type functions are flagged here, not downstream in ALU control.
          case (Func)
            6'b100000, 6'b100010, 6'b100100, 6'b000000, 6'b101010: state_nxt = S_EXEC;
            F_JR:    state_nxt = S_JR;
            default: Illegal   = 1'b1;
          endcase
        end else if (Op == OP_BEQ) begin
          state_nxt = S_BRANCH;
        end else if (Op == OP_J) begin
          state_nxt = S_JUMP;
        end else if (Op == OP_ADDI || Op == OP_ANDI) begin
          state_nxt = S_IMMEX;
        end else begin
          Illegal = 1'b1;
        end
      end

      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        Aluop     = (Op == OP_LW) ? 3'b001 : 3'b010;
        state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        state_nxt = Mem_Rdy ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end

      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        state_nxt = Mem_Rdy ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        ALUSrcA   = 1'b1;
        state_nxt = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        Aluop       = 3'b110;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end

      S_IMMEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        Aluop     = (Op == OP_ANDI) ? 3'b011 : 3'b010;
        state_nxt = S_IMMWB;
      end

      S_IMMWB: RegWrite = 1'b1;

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end

      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule
